// File: rtl/uart_pkg.sv
// Shared UART types: rx FSM states, oversample indices, vote helper.
// Imported by uart_os_tick_gen and uart_rx_os16.
package uart_pkg;

  localparam int DATA_W = 8;

  // Mid-bit sample points within a 16-tick bit slot
  localparam logic [3:0] OS_MID = 4'd8;
  localparam logic [3:0] OS_S0  = 4'd7;
  localparam logic [3:0] OS_S1  = OS_MID;
  localparam logic [3:0] OS_S2  = 4'd9;
  localparam logic [3:0] OS_END = 4'd15;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_e;

  function automatic logic majority3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Oversample tick generator: one-clk tick every CLOCK_FREQ/(BAUD*OS) clks.
// Ports: clk, rst_n (async low), clear (restart phase), tick (pulse out).
module uart_os_tick_gen #(
  parameter int CLOCK_FREQ = 12000000,
  parameter int BAUD_RATE  = 19200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampled UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN)
// with 3-sample majority vote and a show-ahead byte FIFO.
// Ports: clk, rst_n (async low), rxd (async line), enable,
//   data/valid/ready (FIFO head handshake),
//   frame_err, overrun, parity_err (one-clk pulses).
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 12000000,
  parameter int BAUD_RATE  = 19200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rxd,
  input  logic              enable,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  localparam rx_state_e AFTER_DATA = PARITY;
`else
  localparam rx_state_e AFTER_DATA = STOP;
`endif

  logic [1:0]        sync_q;
  logic              rxd_s;
  rx_state_e         state_q;
  logic [3:0]        tidx_q;
  logic [2:0]        bcnt_q;
  logic [DATA_W-1:0] shreg_q;
  logic              s7_q, s8_q, s9_q;
  logic              vpend_q;
  logic              ferr_q, ovr_q;
  logic              start_edge, tick;
  logic              vote, last_tick;
  logic              push, pop, push_ok, full, par_bad;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rxd};
  end

  assign rxd_s = sync_q[1];

  assign start_edge = enable && (state_q == IDLE) && !rxd_s;

  uart_os_tick_gen #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start_edge),
    .tick  (tick)
  );

  // Tick index and mid-bit sampling; vpend_q marks the vote cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tidx_q  <= '0;
      s7_q    <= 1'b1;
      s8_q    <= 1'b1;
      s9_q    <= 1'b1;
      vpend_q <= 1'b0;
    end else if (start_edge) begin
      tidx_q  <= '0;
      vpend_q <= 1'b0;
    end else if (tick) begin
      tidx_q  <= tidx_q + 4'd1;
      vpend_q <= (tidx_q == OS_S2);
      if (tidx_q == OS_S0) s7_q <= rxd_s;
      if (tidx_q == OS_S1) s8_q <= rxd_s;
      if (tidx_q == OS_S2) s9_q <= rxd_s;
    end else begin
      vpend_q <= 1'b0;
    end
  end

  assign vote      = majority3(s7_q, s8_q, s9_q);
  assign last_tick = tick && (tidx_q == OS_END);

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, perr_q;
  assign par_bad    = par_bad_q;
  assign parity_err = perr_q;
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign push = enable && (state_q == STOP) && vpend_q
              && vote && !par_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bcnt_q    <= '0;
      shreg_q   <= '0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
      if (!enable) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (!rxd_s) state_q <= START;
          end
          START: begin
            if (vpend_q && vote) begin
              state_q <= IDLE;
            end else if (last_tick) begin
              state_q <= DATA;
              bcnt_q  <= '0;
            end
          end
          DATA: begin
            if (vpend_q) shreg_q <= {vote, shreg_q[DATA_W-1:1]};
            if (last_tick) begin
              bcnt_q <= bcnt_q + 3'd1;
              if (bcnt_q == 3'd7) state_q <= AFTER_DATA;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (vpend_q) par_bad_q <= ^{shreg_q, vote};
            if (last_tick) state_q <= STOP;
          end
`endif
          // Leave right after the stop vote so a skewed next
          // start edge is not missed.
          STOP: begin
            if (vpend_q) begin
              if (vote) begin
                state_q <= IDLE;
`ifdef UART_RX_PARITY_EN
                perr_q  <= par_bad_q;
`endif
              end else begin
                ferr_q  <= 1'b1;
                state_q <= BREAK_WAIT;
              end
            end
          end
          BREAK_WAIT: begin
            if (rxd_s) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign valid   = (cnt_q != '0);
  assign full    = cnt_q[AW];
  assign pop     = valid && ready;
  assign push_ok = push && (!full || pop);
  assign data    = mem_q[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ovr_q <= push && full && !pop;
      if (push_ok) begin
        mem_q[wr_q] <= shreg_q;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (push_ok && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push_ok && pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed testbench for uart_rx_os16 (DIV=2, 32 clk per bit, depth 4).
// Builds 8E1 frames when UART_RX_PARITY_EN is defined.
module tb_uart_rx_os16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       enable = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, overrun, parity_err;

  int n_chk = 0;
  int n_fail = 0;
  int n_ferr = 0, n_ovr = 0, n_perr = 0, n_multi = 0, n_vcyc = 0;
  int b_ferr, b_ovr, b_perr, b_vcyc;
  logic [7:0] popq[$];

  always #5 clk = ~clk;

  uart_rx_os16 #(
    .CLOCK_FREQ (3200000),
    .BAUD_RATE  (100000),
    .OVERSAMPLE (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .enable     (enable),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  // Inputs change at posedge+2, so negedge values equal what the
  // DUT samples on the following posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && ready) popq.push_back(data);
      if (valid) n_vcyc++;
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      if (parity_err) n_perr++;
      if (int'(frame_err) + int'(overrun) + int'(parity_err) > 1)
        n_multi++;
    end
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_pop(input string tag, input logic [7:0] exp);
    logic [7:0] g;
    g = 8'hxx;
    if (popq.size() != 0) g = popq.pop_front();
    chk(tag, {24'h0, g}, {24'h0, exp});
  endtask

  task automatic snap();
    b_ferr = n_ferr;
    b_ovr  = n_ovr;
    b_perr = n_perr;
    b_vcyc = n_vcyc;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] d,
    input logic par, input logic stp);
`ifdef UART_RX_PARITY_EN
    return {stp, par, d, 1'b0};
`else
    return {1'b0, stp, d, 1'b0};
`endif
  endfunction

`ifdef UART_RX_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif

  // inv: clk offset within every slot to invert for one clk (-1 none)
  task automatic send_frame(input logic [7:0] d, input logic par,
                            input logic stp, input int inv);
    logic [10:0] f;
    f = frame_bits(d, par, stp);
    for (int s = 0; s < NSLOT; s++)
      for (int c = 0; c < 32; c++) begin
        rxd = (c == inv) ? ~f[s] : f[s];
        tick_n(1);
      end
    rxd = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] d, input int inv);
    send_frame(d, ^d, 1'b1, inv);
  endtask

  task automatic pop_one();
    ready = 1'b1;
    tick_n(1);
    ready = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_data"}, 32'(data), 32'h00);
    chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
    chk({tag, "_ovr"}, 32'(overrun), 32'd0);
    chk({tag, "_perr"}, 32'(parity_err), 32'd0);
  endtask

  initial begin
    logic [10:0] f;
    logic [7:0] heads [4];
    heads[0] = 8'h3C;
    heads[1] = 8'hC3;
    heads[2] = 8'h00;
    heads[3] = 8'hFF;

    tick_n(5);
    chk_reset_outs("rst0");
    rst_n = 1'b1;
    tick_n(20);

    // single byte, consumer always ready
    ready = 1'b1;
    snap();
    send_good(8'hA5, -1);
    tick_n(40);
    expect_pop("a5_data", 8'hA5);
    chk("a5_vcyc", 32'(n_vcyc - b_vcyc), 32'd1);
    chk("a5_ferr", 32'(n_ferr - b_ferr), 32'd0);
    chk("a5_ovr", 32'(n_ovr - b_ovr), 32'd0);

    // fill FIFO then overflow by one
    ready = 1'b0;
    snap();
    send_good(8'h3C, -1);
    send_good(8'hC3, -1);
    send_good(8'h00, -1);
    send_good(8'hFF, -1);
    send_good(8'h55, -1);
    tick_n(40);
    chk("ovr_cnt", 32'(n_ovr - b_ovr), 32'd1);
    chk("ovr_ferr", 32'(n_ferr - b_ferr), 32'd0);
    chk("ovr_valid", 32'(valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("head%0d", i), 32'(data), 32'(heads[i]));
      pop_one();
    end
    chk("drain_valid", 32'(valid), 32'd0);
    for (int i = 0; i < 4; i++)
      expect_pop($sformatf("pop%0d", i), heads[i]);

    // short low glitch is rejected silently
    ready = 1'b1;
    snap();
    rxd = 1'b0;
    tick_n(10);
    rxd = 1'b1;
    tick_n(80);
    chk("glitch_pops", 32'(popq.size()), 32'd0);
    chk("glitch_ferr", 32'(n_ferr - b_ferr), 32'd0);
    send_good(8'h81, -1);
    tick_n(40);
    expect_pop("after_glitch", 8'h81);

    // bad stop bit then held break: one frame_err only
    snap();
    send_frame(8'h42, ^8'h42, 1'b0, -1);
    rxd = 1'b0;
    tick_n(200);
    rxd = 1'b1;
    tick_n(64);
    chk("brk_ferr", 32'(n_ferr - b_ferr), 32'd1);
    chk("brk_pops", 32'(popq.size()), 32'd0);
    send_good(8'h17, -1);
    tick_n(40);
    expect_pop("after_brk", 8'h17);

    // receiver disabled: nothing accepted
    enable = 1'b0;
    send_good(8'h33, -1);
    tick_n(40);
    chk("dis_pops", 32'(popq.size()), 32'd0);
    enable = 1'b1;
    tick_n(40);

    // one-clk inversion at sample 8 (offset 18) of every slot
    ready = 1'b0;
    snap();
    send_good(8'h5A, 18);
    tick_n(40);
    chk("vote_valid", 32'(valid), 32'd1);
    chk("vote_data", 32'(data), 32'h5A);
    chk("vote_ferr", 32'(n_ferr - b_ferr), 32'd0);

    // reset in the middle of bit 4
    f = frame_bits(8'h99, ^8'h99, 1'b1);
    for (int c = 0; c < 32 * 5 + 10; c++) begin
      rxd = f[c / 32];
      tick_n(1);
    end
    rst_n = 1'b0;
    tick_n(3);
    chk_reset_outs("rst_mid");
    rxd = 1'b1;
    tick_n(2);
    rst_n = 1'b1;
    ready = 1'b1;
    tick_n(40);
    send_good(8'h99, -1);
    tick_n(40);
    expect_pop("after_rst", 8'h99);
    chk("after_rst_cnt", 32'(popq.size()), 32'd0);

`ifdef UART_RX_PARITY_EN
    snap();
    send_frame(8'h99, 1'b1, 1'b1, -1);
    tick_n(40);
    chk("par_err", 32'(n_perr - b_perr), 32'd1);
    chk("par_pops", 32'(popq.size()), 32'd0);
`else
    chk("perr_none", 32'(n_perr), 32'd0);
`endif
    chk("pulse_overlap", 32'(n_multi), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- 8N1 UART receiver that pairs with uart_tx_8n1 on the host link and feeds incoming bytes to the FFT sample loader.
- Uses 16x oversampling, a 2-flop input synchronizer and 3-sample majority voting.
- Realigns to every start edge and buffers received bytes in a small show-ahead FIFO with a valid/ready output handshake.
- Reports framing errors and FIFO overruns as one-cycle pulses.

Parameters:
- CLOCK_FREQ, 12000000, system clock in Hz.
- BAUD_RATE, 19200, line bit rate.
- OVERSAMPLE, 16, ticks per bit. Fixed at 16; the sample indices below assume it.
- FIFO_DEPTH, 4, byte buffer depth. Power of 2, 2..16.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rxd  input  1  asynchronous serial line, idle high.
- enable  input  1  receiver enable.
- data  output  8  FIFO head byte, valid only while valid=1.
- valid  output  1  FIFO non-empty.
- ready  input  1  consumer pop; a pop occurs when valid&&ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: good byte dropped because FIFO full.
- parity_err  output  1  one-cycle pulse; only driven by the optional feature, tied 0 otherwise.

Behaviour:
- Reset (async assert, sync release on clk): synchronizer flops=1; FSM=IDLE; tick counter=0; FIFO empty; valid=0, data=8'h00, frame_err=0, overrun=0, parity_err=0.
- Sync: rxd_s is rxd after 2 flops. All decisions use rxd_s, giving 2 clk input latency.
- Tick generator:
  - DIV = CLOCK_FREQ/(BAUD_RATE*16), integer, must be >=1.
  - Counter runs 0..DIV-1; tick is high for 1 clk when count==DIV-1.
  - Counter and tick index (0..15) are cleared on the cycle IDLE leaves on a start edge.
- Voting: in each bit slot, rxd_s is captured at tick indices 7, 8 and 9. The bit value is the majority of the three, evaluated on the clk after tick 9.
- FSM states: IDLE, START, DATA, STOP, BREAK_WAIT. Transitions:
  - IDLE: if enable && rxd_s==0 -> START.
  - START: majority==1 -> IDLE (glitch rejected, nothing reported). Otherwise at tick index 15 -> DATA with bit_cnt=0.
  - DATA: shift the voted bit into the byte LSB-first. After the bit_cnt==7 slot completes at tick 15 -> STOP.
  - STOP: on the voted stop bit:
    - 1: push byte to FIFO, go to IDLE immediately after tick 9 (early return so back-to-back frames with clock skew are not missed).
    - 0: pulse frame_err, discard byte -> BREAK_WAIT.
  - BREAK_WAIT: stay until rxd_s==1, then -> IDLE. A held-low line gives exactly one frame_err.
- enable low: FSM forced to IDLE on the next clk, aborting any partial frame with no error report. FIFO contents and the pop handshake are unaffected.
- FIFO (show-ahead):
  - data always equals the head entry.
  - Push when empty: valid=1 on the next clk.
  - Pop of the last entry: valid=0 on the next clk.
  - Push while full with no pop: byte dropped, overrun pulses, FIFO unchanged.
  - Push while full with a simultaneous pop: both accepted, count unchanged, no overrun.
  - Pointers wrap modulo FIFO_DEPTH; count is tracked with one extra bit.
- Latency: valid rises 1 clk after the stop-bit vote, which itself is 1 clk after tick 9 of the stop slot.
- Error pulses are never asserted in the same cycle as each other.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined: frame is 8E1. A PARITY state is inserted between DATA and STOP. The voted parity bit must make even parity over data+parity. On mismatch, parity_err pulses 1 clk when STOP resolves and the byte is discarded. frame_err takes priority: parity_err is suppressed if the stop bit is also bad.
- Undefined: 8N1, PARITY state absent, parity_err tied 0.

Decomposition:
- Package uart_pkg holds:
  - the rx FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK_WAIT);
  - localparam OS_MID=8 and sample indices 7, 8, 9;
  - data width 8;
  - a majority3 function.
- One sub-module, uart_os_tick_gen: parameters CLOCK_FREQ, BAUD_RATE, OVERSAMPLE; ports clk, rst_n, clear, tick. It is reusable by uart_tx_8n1 later.
- FIFO stays inline.

Test Plan (CLOCK_FREQ=3200000, BAUD_RATE=100000, DIV=2, 32 clk/bit, FIFO_DEPTH=4):
- Reset, then send 8'hA5 with ready=1 -> valid pulses 1 clk with data=8'hA5; frame_err=0, overrun=0.
- Send 8'h3C, 8'hC3, 8'h00, 8'hFF back-to-back, ready=0, then a 5th byte 8'h55 -> FIFO holds 3C,C3,00,FF and overrun pulses once; popping yields them in order; valid=0 after the 4th pop.
- 10-clk low glitch on idle rxd -> no byte, no error; a following valid 8'h81 is received correctly.
- Frame 8'h42 with stop bit low, then line held low 200 clk -> exactly one frame_err, no push; after release, next byte 8'h17 received.
- Send 8'h5A with a single-clk inversion at sample index 8 of every bit -> data=8'h5A (majority vote).
- Pull rst_n low mid-byte (bit 4), release, then send 8'h99 -> outputs at reset values during reset; only 8'h99 delivered. With UART_RX_PARITY_EN, send 8'h99 with parity=1 -> parity_err pulses, no push.
